// File: rtl/spi_regs_pkg.sv
// Shared constants and types for the SPI write-only register slave.
package spi_regs_pkg;

    // Frame layout: 1 R/W bit, 7 address bits, 8 data bits, MSB first.
    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 8;

    // Counter must hold FRAME_BITS+1 so that over-length frames stay visible.
    localparam int CNT_W = $clog2(FRAME_BITS + 2);

    localparam int NUM_REGS = 5;

    localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_BITS-1:0] ADDR_PWM_DUTY  = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a level flop
// and registered rise/fall pulses. Pulses are held off until the chain has
// been flushed of its reset value, so a pin already at the opposite level
// when reset releases never produces a spurious edge.
module sync_edge_detect #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              level_q;
    logic              rise_q;
    logic              fall_q;
    logic [STAGES:0]   valid_q;

    // Synchroniser chain, edge-detect flop and flush tracker.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {STAGES{RESET_VAL}};
            level_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d_i};
            level_q <= sync_q[STAGES-1];
            rise_q  <= valid_q[STAGES] &  sync_q[STAGES-1] & ~level_q;
            fall_q  <= valid_q[STAGES] & ~sync_q[STAGES-1] &  level_q;
            valid_q <= {valid_q[STAGES-1:0], 1'b1};
        end
    end

    // Level output is time-aligned with the pulses for the data pin.
    assign q_o    = level_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register slave. SCLK/COPI/nCS are sampled as data in
// the clk domain; a 16-bit frame (W, addr[6:0], data[7:0]) writes one of five
// control registers when nCS rises after exactly 16 SCLK rising edges.
module spi_peripheral
    import spi_regs_pkg::*;
#(
    parameter int                   SYNC_STAGES = 2,
    parameter logic [ADDR_BITS-1:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    logic sclk_rise;
    logic copi_s;
    logic ncs_rise;
    logic ncs_fall;
    logic sclk_level_unused;
    logic sclk_fall_unused;
    logic copi_rise_unused;
    logic copi_fall_unused;
    logic ncs_level_unused;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (sclk),
        .q_o    (sclk_level_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall_unused)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (copi),
        .q_o    (copi_s),
        .rise_o (copi_rise_unused),
        .fall_o (copi_fall_unused)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (ncs),
        .q_o    (ncs_level_unused),
        .rise_o (ncs_rise),
        .fall_o (ncs_fall)
    );

    spi_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0]  regs_q [NUM_REGS];
    logic                  commit;

    logic [ADDR_BITS-1:0]  frame_addr;
    logic [DATA_BITS-1:0]  frame_data;
    logic                  frame_ok;

    assign frame_addr = shift_q[FRAME_BITS-2 -: ADDR_BITS];
    assign frame_data = shift_q[DATA_BITS-1:0];
    assign frame_ok   = (cnt_q == CNT_W'(FRAME_BITS))
                      && shift_q[FRAME_BITS-1]
                      && (frame_addr <= MAX_ADDR);

    // FSM state, bit counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: start on nCS fall, shift on SCLK rise, commit on nCS rise.
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // nCS rise wins over a coincident SCLK edge; that edge is dropped.
                if (ncs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
                    if (cnt_q != CNT_W'(FRAME_BITS + 1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            COMMIT: begin
                commit  = frame_ok;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control register file: one register updated per accepted frame.
    // NOTE: these five bytes drive live enables downstream, so unlike a RAM they
    // must reset to a known safe value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            case (frame_addr)
                ADDR_EN_OUT_LO: regs_q[0] <= frame_data;
                ADDR_EN_OUT_HI: regs_q[1] <= frame_data;
                ADDR_EN_PWM_LO: regs_q[2] <= frame_data;
                ADDR_EN_PWM_HI: regs_q[3] <= frame_data;
                ADDR_PWM_DUTY:  regs_q[4] <= frame_data;
                default: ;
            endcase
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI mode-0, write-only register slave that consumes the raw SCLK/COPI/nCS pins from the top-level Tiny Tapeout wrapper.
- Drives the five control registers read by the downstream PWM/output stage: 16 output enables, 16 PWM enables and one 8-bit duty cycle.
- SCLK is treated as data, never as a clock.
  - All pins are synchronised into clk.
  - Edges are detected in the clk domain.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per input pin before edge detection (minimum 2).
- MAX_ADDR, 7'h04, highest valid register address; writes above it are discarded.
- FRAME_BITS, 16, bits per transaction: 1 R/W, 7 address, 8 data.

Ports:
- clk  input  1  system clock (at least 4x the SCLK frequency).
- rst_n  input  1  asynchronous active-low reset.
- sclk  input  1  raw SPI clock pin, asynchronous.
- copi  input  1  raw SPI data pin, asynchronous.
- ncs  input  1  raw active-low chip select, asynchronous.
- en_reg_out_7_0  output  8  register 0x00.
- en_reg_out_15_8  output  8  register 0x01.
- en_reg_pwm_7_0  output  8  register 0x02.
- en_reg_pwm_15_8  output  8  register 0x03.
- pwm_duty_cycle  output  8  register 0x04.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low: clk, rst_n.
  - All five registers reset to 8'h00.
  - Synchroniser chains reset to sclk=0, copi=0, ncs=1.
  - Bit counter resets to 0; shift register resets to 0; FSM resets to IDLE.
- Synchronisation:
  - Each pin passes through SYNC_STAGES flops, plus one extra flop for edge detection.
  - sclk_rise = synced high and previous low; ncs_fall and ncs_rise are defined the same way.
- Frame format:
  - MSB first, sampled on sclk_rise only; sclk falling edges are ignored.
  - bit15 = R/W (1 = write); bits14:8 = address; bits7:0 = data.
- FSM:
  - IDLE: on ncs_fall, clear bit counter and shift register, go to SHIFT.
  - SHIFT, sclk_rise: shift the synced copi into the LSB. The counter increments and saturates at FRAME_BITS+1, so over-length frames are detectable.
  - SHIFT, ncs_rise: go to COMMIT. This takes priority over a sclk_rise in the same cycle; that edge is dropped.
  - COMMIT (one cycle): if counter == FRAME_BITS, R/W == 1 and address <= MAX_ADDR, write data to the addressed register. Otherwise make no change. Always return to IDLE.
- Latency: the register output changes on the clk edge two cycles after the cycle in which ncs_rise is asserted. That is 2+SYNC_STAGES+1 clk edges after the physical nCS rise, i.e. 5 with defaults.
- Discarded frames, with no register change:
  - short frame (<16 bits);
  - long frame (>16 bits);
  - read frame (bit15 = 0);
  - address 0x05–0x7F.
- Writes: exactly one register changes per valid frame; the others hold.
- nCS high: SCLK/COPI activity is ignored and the counter does not move.
- Reset mid-frame: the frame is aborted and the registers clear. After reset, a frame needs a fresh ncs_fall; a held-low nCS at reset release does not start one.
- No read-back path; the block has no MISO.

Decomposition:
- Shared package spi_regs_pkg:
  - address constants ADDR_EN_OUT_LO=0x00, ADDR_EN_OUT_HI=0x01, ADDR_EN_PWM_LO=0x02, ADDR_EN_PWM_HI=0x03, ADDR_PWM_DUTY=0x04;
  - FRAME_BITS;
  - FSM state enum {IDLE, SHIFT, COMMIT}.
- Sub-module: sync_edge_detect. It holds one SYNC_STAGES-deep synchroniser plus rise/fall pulses, with reset value as a parameter. It is instantiated three times.

Test Plan:
1. Reset → all five outputs 8'h00; pulse rst_n mid-frame → outputs 8'h00 and the next valid frame still commits.
2. Write frame 16'h80F0 (addr 0x00, data 0xF0) → en_reg_out_7_0=0xF0 exactly 5 clk after nCS rise; the other registers stay 0x00.
3. Writes 0x81AA, 0x8255, 0x83FF, 0x8480 back-to-back, with nCS high 2 SCLK periods between frames → regs 0x01..0x04 = 0xAA, 0x55, 0xFF, 0x80.
4. Read frame 0x04CC, and write to address 0x05 (0x85CC) → no register changes.
5. 15-bit frame and 17-bit frame each targeting 0x84 with data 0x33 → pwm_duty_cycle unchanged; a following correct 0x8433 → 0x33.
6. SCLK toggled with nCS held high, then SCLK at clk/4 with random jitter inside a valid frame 0x8011 → registers unchanged after the first part; en_reg_out_7_0 = 0x11 after the second.
